// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop input synchroniser, 3-sample majority vote per bit,
// configurable data/parity/stop format and a registered ready/valid word output.
module uart_rx_os #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_tick,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int M  = OVERSAMPLE / 2;

  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_S0   = TW'(M - 1);
  localparam logic [TW-1:0] TICK_S1   = TW'(M);
  localparam logic [TW-1:0] TICK_DEC  = TW'(M + 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             sync_q, sync_d;
  logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
  logic [3:0]             bit_idx_q, bit_idx_d;
  logic [1:0]             samp_q, samp_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_acc_q, par_acc_d;
  logic                   perr_acc_q, perr_acc_d;
  logic                   ferr_acc_q, ferr_acc_d;

  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   parity_err_q, parity_err_d;
  logic                   overrun_q, overrun_d;
  logic                   busy_q, busy_d;

  logic rxs;
  logic maj;
  logic at_dec;
  logic at_end;
  logic complete;
  logic word_ferr;

  assign rxs    = sync_q[1];
  assign maj    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);
  assign at_dec = sample_tick && (tick_cnt_q == TICK_DEC);
  assign at_end = sample_tick && (tick_cnt_q == TICK_LAST);

  always_comb begin
    sync_d = {sync_q[0], rx_in};
  end

  // Bit timing, sampling and frame sequencing; the third vote is the live rxs at the decision tick.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    samp_d     = samp_q;
    shift_d    = shift_q;
    par_acc_d  = par_acc_q;
    perr_acc_d = perr_acc_q;
    ferr_acc_d = ferr_acc_q;
    complete   = 1'b0;
    word_ferr  = ferr_acc_q | ~maj;

    if (state_q != S_IDLE && sample_tick) begin
      tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TW'(1);
      if (tick_cnt_q == TICK_S0) samp_d[0] = rxs;
      if (tick_cnt_q == TICK_S1) samp_d[1] = rxs;
    end

    case (state_q)
      S_IDLE: begin
        if (sample_tick && !rxs) begin
          state_d    = S_START;
          tick_cnt_d = TW'(1);
          bit_idx_d  = '0;
          par_acc_d  = 1'b0;
          perr_acc_d = 1'b0;
          ferr_acc_d = 1'b0;
        end
      end
      S_START: begin
        if (at_dec && maj) begin
          state_d    = S_IDLE;
          tick_cnt_d = '0;
        end else if (at_end) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (at_dec) begin
          shift_d   = {maj, shift_q[DATA_BITS-1:1]};
          par_acc_d = par_acc_q ^ maj;
        end
        if (at_end) begin
          if (bit_idx_q == DATA_LAST) begin
            bit_idx_d = '0;
            state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (at_dec) begin
          perr_acc_d = (PARITY == 1) ? (par_acc_q ^ maj) : ~(par_acc_q ^ maj);
        end
        if (at_end) begin
          state_d   = S_STOP;
          bit_idx_d = '0;
        end
      end
      S_STOP: begin
        if (at_dec) begin
          if (bit_idx_q == STOP_LAST) begin
            complete   = 1'b1;
            state_d    = S_IDLE;
            tick_cnt_d = '0;
            bit_idx_d  = '0;
          end else begin
            ferr_acc_d = ferr_acc_q | ~maj;
          end
        end else if (at_end) begin
          bit_idx_d = bit_idx_q + 4'd1;
        end
      end
      default: begin
        state_d    = S_IDLE;
        tick_cnt_d = '0;
        bit_idx_d  = '0;
      end
    endcase
  end

  // A finished word loads when the holding register is empty or being drained this cycle.
  always_comb begin
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    overrun_d    = 1'b0;
    busy_d       = (state_d != S_IDLE);

    if (complete) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d    = shift_q;
        rx_valid_d   = 1'b1;
        frame_err_d  = word_ferr;
        parity_err_d = perr_acc_q & (PARITY != 0);
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= 2'b11;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      samp_q     <= 2'b11;
      shift_q    <= '0;
      par_acc_q  <= 1'b0;
      perr_acc_q <= 1'b0;
      ferr_acc_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      samp_q     <= samp_d;
      shift_q    <= shift_d;
      par_acc_q  <= par_acc_d;
      perr_acc_q <= perr_acc_d;
      ferr_acc_q <= ferr_acc_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign parity_err  = parity_err_q;
  assign overrun_err = overrun_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: an 8N1 instance and a 7E2 instance driven one tick-slot at a time,
// checked against directed vectors, hand-written corner sequences and a random frame model.
module tb_uart_rx_os;

  localparam int OS = 16;
  localparam int M  = OS / 2;

  typedef struct {
    int         which;
    logic [8:0] data;
    logic       par_bit;
    logic [1:0] stop_vals;
    int         glitch;
    logic [8:0] exp_data;
    logic       exp_ferr;
    logic       exp_perr;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_tick;
  logic       rx8, rx7, ready8, ready7;
  logic [7:0] data8;
  logic [6:0] data7;
  logic       valid8, ferr8, perr8, ovr8, busy8;
  logic       valid7, ferr7, perr7, ovr7, busy7;

  int n_checks = 0;
  int n_fail   = 0;

  int ovr_cnt8 = 0, ovr_run8 = 0, ovr_maxrun8 = 0, ovr_cnt7 = 0;
  bit collect = 1'b0;
  logic [10:0] got8[$], got7[$], exp8[$], exp7[$];

  always #5 clk = ~clk;

  uart_rx_os #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(OS)) dut8 (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .rx_in(rx8),
    .rx_data(data8), .rx_valid(valid8), .rx_ready(ready8),
    .frame_err(ferr8), .parity_err(perr8), .overrun_err(ovr8), .busy(busy8)
  );

  uart_rx_os #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .OVERSAMPLE(OS)) dut7 (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .rx_in(rx7),
    .rx_data(data7), .rx_valid(valid7), .rx_ready(ready7),
    .frame_err(ferr7), .parity_err(perr7), .overrun_err(ovr7), .busy(busy7)
  );

  // One-cycle sample_tick every fourth clock, changed on the falling edge.
  initial begin
    sample_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (ovr8) begin
      ovr_cnt8 <= ovr_cnt8 + 1;
      ovr_run8 <= ovr_run8 + 1;
      if (ovr_run8 + 1 > ovr_maxrun8) ovr_maxrun8 <= ovr_run8 + 1;
    end else begin
      ovr_run8 <= 0;
    end
    if (ovr7) ovr_cnt7 <= ovr_cnt7 + 1;
    if (collect && valid8 && ready8) got8.push_back({perr8, ferr8, 1'b0, data8});
    if (collect && valid7 && ready7) got7.push_back({perr7, ferr7, 2'b00, data7});
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic waitTick();
    @(posedge clk);
    while (!sample_tick) @(posedge clk);
  endtask

  // Each slot value is sampled by exactly one DUT tick (the one after it is driven).
  task automatic driveSlot(input int which, input logic v);
    waitTick();
    @(negedge clk);
    if (which == 0) rx8 = v;
    else rx7 = v;
  endtask

  task automatic driveIdle(input int which, input int n);
    repeat (n) driveSlot(which, 1'b1);
  endtask

  task automatic applyStimulus(input int which, input logic [8:0] data, input logic par_bit,
                               input logic [1:0] stop_vals, input int glitch, input int slot_limit);
    logic slots[$];
    int nbits, nstop;
    nbits = (which == 0) ? 8 : 7;
    nstop = (which == 0) ? 1 : 2;
    for (int k = 0; k < OS; k++) slots.push_back(1'b0);
    for (int b = 0; b < nbits; b++)
      for (int k = 0; k < OS; k++) slots.push_back(data[b]);
    if (which != 0)
      for (int k = 0; k < OS; k++) slots.push_back(par_bit);
    for (int s = 0; s < nstop; s++)
      for (int k = 0; k < OS; k++) slots.push_back(stop_vals[s]);
    if (glitch >= 0 && glitch < slots.size()) slots[glitch] = ~slots[glitch];
    for (int j = 0; j < slots.size() && j < slot_limit; j++) driveSlot(which, slots[j]);
  endtask

  task automatic waitValid(input int which, input string name);
    int cnt = 0;
    while (((which == 0) ? valid8 : valid7) == 1'b0 && cnt < 4000) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput(name, 32'((which == 0) ? valid8 : valid7), 32'd1);
  endtask

  task automatic acceptWord(input int which, input string name);
    @(negedge clk);
    if (which == 0) ready8 = 1'b1;
    else ready7 = 1'b1;
    @(negedge clk);
    if (which == 0) ready8 = 1'b0;
    else ready7 = 1'b0;
    checkOutput(name, 32'((which == 0) ? valid8 : valid7), 32'd0);
  endtask

  initial begin : main
    vec_t vecs[10];
    int   nvalid;
    logic [7:0] seen_data;
    logic seen_f, seen_p;
    int   base8, base7;
    logic [8:0] d;
    logic pb, pe;
    int   g;

    vecs[0] = '{which:0, data:9'h0A5, par_bit:1'b0, stop_vals:2'b11, glitch:-1,  exp_data:9'h0A5, exp_ferr:1'b0, exp_perr:1'b0};
    vecs[1] = '{which:0, data:9'h03C, par_bit:1'b0, stop_vals:2'b10, glitch:-1,  exp_data:9'h03C, exp_ferr:1'b1, exp_perr:1'b0};
    vecs[2] = '{which:0, data:9'h0F0, par_bit:1'b0, stop_vals:2'b11, glitch:4*OS+M,   exp_data:9'h0F0, exp_ferr:1'b0, exp_perr:1'b0};
    vecs[3] = '{which:0, data:9'h000, par_bit:1'b0, stop_vals:2'b11, glitch:M-1,      exp_data:9'h000, exp_ferr:1'b0, exp_perr:1'b0};
    vecs[4] = '{which:1, data:9'h041, par_bit:1'b1, stop_vals:2'b11, glitch:-1,  exp_data:9'h041, exp_ferr:1'b0, exp_perr:1'b1};
    vecs[5] = '{which:1, data:9'h041, par_bit:1'b0, stop_vals:2'b11, glitch:-1,  exp_data:9'h041, exp_ferr:1'b0, exp_perr:1'b0};
    vecs[6] = '{which:1, data:9'h07F, par_bit:1'b1, stop_vals:2'b11, glitch:-1,  exp_data:9'h07F, exp_ferr:1'b0, exp_perr:1'b0};
    vecs[7] = '{which:1, data:9'h02A, par_bit:1'b1, stop_vals:2'b01, glitch:-1,  exp_data:9'h02A, exp_ferr:1'b1, exp_perr:1'b0};
    vecs[8] = '{which:0, data:9'h0FF, par_bit:1'b0, stop_vals:2'b11, glitch:9*OS+M+1, exp_data:9'h0FF, exp_ferr:1'b0, exp_perr:1'b0};
    vecs[9] = '{which:1, data:9'h055, par_bit:1'b0, stop_vals:2'b11, glitch:8*OS+M,   exp_data:9'h055, exp_ferr:1'b0, exp_perr:1'b0};

    rst = 1'b1; rx8 = 1'b1; rx7 = 1'b1; ready8 = 1'b0; ready7 = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_data8",  32'(data8),  32'd0);
    checkOutput("reset_valid8", 32'(valid8), 32'd0);
    checkOutput("reset_ferr8",  32'(ferr8),  32'd0);
    checkOutput("reset_perr8",  32'(perr8),  32'd0);
    checkOutput("reset_ovr8",   32'(ovr8),   32'd0);
    checkOutput("reset_busy8",  32'(busy8),  32'd0);
    checkOutput("reset_valid7", 32'(valid7), 32'd0);
    checkOutput("reset_busy7",  32'(busy7),  32'd0);

    $display("[TB] basic 8N1 with rx_ready held high");
    ready8 = 1'b1;
    nvalid = 0; seen_data = '0; seen_f = 1'b0; seen_p = 1'b0;
    fork
      begin
        applyStimulus(0, 9'h0A5, 1'b0, 2'b11, -1, 100000);
        driveIdle(0, 20);
      end
      begin
        for (int c = 0; c < 1000; c++) begin
          @(negedge clk);
          if (valid8) begin
            nvalid++;
            seen_data = data8; seen_f = ferr8; seen_p = perr8;
          end
        end
      end
    join
    ready8 = 1'b0;
    checkOutput("basic_valid_cycles", 32'(nvalid), 32'd1);
    checkOutput("basic_data",  32'(seen_data), 32'h0A5);
    checkOutput("basic_ferr",  32'(seen_f), 32'd0);
    checkOutput("basic_perr",  32'(seen_p), 32'd0);
    checkOutput("basic_busy_after", 32'(busy8), 32'd0);

    $display("[TB] directed vector table");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].which, vecs[i].data, vecs[i].par_bit, vecs[i].stop_vals, vecs[i].glitch, 100000);
      driveIdle(vecs[i].which, 40);
      waitValid(vecs[i].which, $sformatf("vec%0d_valid", i));
      if (vecs[i].which == 0) begin
        checkOutput($sformatf("vec%0d_data", i), 32'(data8), 32'(vecs[i].exp_data));
        checkOutput($sformatf("vec%0d_ferr", i), 32'(ferr8), 32'(vecs[i].exp_ferr));
        checkOutput($sformatf("vec%0d_perr", i), 32'(perr8), 32'(vecs[i].exp_perr));
        checkOutput($sformatf("vec%0d_busy", i), 32'(busy8), 32'd0);
      end else begin
        checkOutput($sformatf("vec%0d_data", i), 32'(data7), 32'(vecs[i].exp_data));
        checkOutput($sformatf("vec%0d_ferr", i), 32'(ferr7), 32'(vecs[i].exp_ferr));
        checkOutput($sformatf("vec%0d_perr", i), 32'(perr7), 32'(vecs[i].exp_perr));
        checkOutput($sformatf("vec%0d_busy", i), 32'(busy7), 32'd0);
      end
      acceptWord(vecs[i].which, $sformatf("vec%0d_accept", i));
    end
    checkOutput("table_no_overrun8", 32'(ovr_cnt8), 32'd0);
    checkOutput("table_no_overrun7", 32'(ovr_cnt7), 32'd0);

    $display("[TB] three-tick glitch on idle line");
    driveSlot(0, 1'b0); driveSlot(0, 1'b0); driveSlot(0, 1'b0); driveSlot(0, 1'b1);
    checkOutput("glitch_busy_during", 32'(busy8), 32'd1);
    driveIdle(0, 40);
    checkOutput("glitch_no_valid", 32'(valid8), 32'd0);
    checkOutput("glitch_idle", 32'(busy8), 32'd0);

    $display("[TB] overrun with back-to-back frames");
    base8 = ovr_cnt8;
    applyStimulus(0, 9'h011, 1'b0, 2'b11, -1, 100000);
    applyStimulus(0, 9'h022, 1'b0, 2'b11, -1, 100000);
    driveIdle(0, 40);
    checkOutput("ovr_valid_held", 32'(valid8), 32'd1);
    checkOutput("ovr_data_held", 32'(data8), 32'h11);
    checkOutput("ovr_pulse_count", 32'(ovr_cnt8 - base8), 32'd1);
    checkOutput("ovr_pulse_width", 32'(ovr_maxrun8), 32'd1);
    acceptWord(0, "ovr_accept");
    driveIdle(0, 10);
    checkOutput("ovr_dropped_word", 32'(valid8), 32'd0);

    $display("[TB] reset in the middle of data bit 4");
    applyStimulus(0, 9'h0C3, 1'b0, 2'b11, -1, 5*OS+5);
    checkOutput("midrst_busy_before", 32'(busy8), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    rx8 = 1'b1;
    @(negedge clk);
    checkOutput("midrst_data",  32'(data8),  32'd0);
    checkOutput("midrst_valid", 32'(valid8), 32'd0);
    checkOutput("midrst_busy",  32'(busy8),  32'd0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    driveIdle(0, 40);
    checkOutput("midrst_no_word", 32'(valid8), 32'd0);
    applyStimulus(0, 9'h05A, 1'b0, 2'b11, -1, 100000);
    driveIdle(0, 40);
    waitValid(0, "midrst_5a_valid");
    checkOutput("midrst_5a_data", 32'(data8), 32'h5A);
    checkOutput("midrst_5a_ferr", 32'(ferr8), 32'd0);
    acceptWord(0, "midrst_5a_accept");

    $display("[TB] random back-to-back frames against the reference model");
    ready8 = 1'b1;
    ready7 = 1'b1;
    base8 = ovr_cnt8;
    base7 = ovr_cnt7;
    @(negedge clk);
    collect = 1'b1;
    for (int n = 0; n < 12; n++) begin
      d = 9'($urandom_range(0, 255));
      g = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 9)) * OS + M - 1 + int'($urandom_range(0, 2)) : -1;
      exp8.push_back({2'b00, d});
      applyStimulus(0, d, 1'b0, 2'b11, g, 100000);
    end
    driveIdle(0, 40);
    for (int n = 0; n < 12; n++) begin
      d  = 9'($urandom_range(0, 127));
      pb = 1'($urandom_range(0, 1));
      pe = pb ^ (^d[6:0]);
      g  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 10)) * OS + M - 1 + int'($urandom_range(0, 2)) : -1;
      exp7.push_back({pe, 1'b0, d});
      applyStimulus(1, d, pb, 2'b11, g, 100000);
    end
    driveIdle(1, 40);
    collect = 1'b0;
    checkOutput("rand8_count", 32'(got8.size()), 32'(exp8.size()));
    checkOutput("rand7_count", 32'(got7.size()), 32'(exp7.size()));
    for (int i = 0; i < exp8.size() && i < got8.size(); i++)
      checkOutput($sformatf("rand8_word%0d", i), 32'(got8[i]), 32'(exp8[i]));
    for (int i = 0; i < exp7.size() && i < got7.size(); i++)
      checkOutput($sformatf("rand7_word%0d", i), 32'(got7[i]), 32'(exp7[i]));
    checkOutput("rand8_no_overrun", 32'(ovr_cnt8 - base8), 32'd0);
    checkOutput("rand7_no_overrun", 32'(ovr_cnt7 - base7), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
